action_cfg_ctrl: RTL and testbench
==================================

Name: action_cfg_ctrl

Overview:
- Per-stage configuration controller for the action word consumed by the stage's crossbar/ALU bank.
- Accepts a narrow 32-bit configuration beat stream and writes 64-bit sub-action entries into a shadow bank.
- On a commit command it swaps the shadow bank into the active bank (action_out). The swap happens only when no PHV is in flight, so a packet never sees a half-updated action word.

Parameters:
- STAGE_ID, 0, stage number this controller answers to.
- ACT_LEN, 64, width of one sub-action slot.
- C_NUM_PHVS, 65, number of slots (64 containers plus 1 control slot).
- CFG_W, 32, configuration beat width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_in_data  in  CFG_W  configuration beat
- cfg_in_valid  in  1  beat valid
- cfg_in_last  in  1  final beat of packet
- cfg_ready_out  out  1  beat accepted when valid&&ready
- phv_in_valid  in  1  PHV entering the stage this cycle
- pipe_busy  in  1  PHV in flight inside crossbar/ALUs
- action_out  out  ACT_LEN*C_NUM_PHVS  active action word
- action_out_valid  out  1  high after first commit
- commit_done  out  1  one-cycle pulse when active bank updates
- cfg_err  out  1  sticky protocol error

Behaviour:
- Reset: rst_n is asynchronous and active-low. Shadow and active banks = 0, action_out_valid=0, commit_done=0, cfg_err=0, cfg_ready_out=1, state=IDLE. A reset mid-packet or mid-commit discards everything.
- Slot k maps to action_out[ACT_LEN*C_NUM_PHVS-1 - k*ACT_LEN -: ACT_LEN]. Slot 0 is the MSB slot.
- Header beat fields:
  - [31:24] stage id
  - [23:17] slot index
  - [16] commit flag
  - [15:0] reserved, ignored
- Write packet: header(commit=0) + HI beat (slot bits [63:32]) + LO beat (bits [31:0]) = 3 beats, last on the LO beat only.
- Commit packet: header(commit=1), 1 beat, last=1.
- States:
  - IDLE: waits for a header beat.
    - Stage id != STAGE_ID: go to DROP unless last=1.
    - commit=1 with last=1: go to COMMIT_WAIT.
    - commit=1 with last=0: set cfg_err, go to DROP.
    - commit=0, slot index >= C_NUM_PHVS: set cfg_err, go to DROP (or stay in IDLE if last=1).
    - commit=0, valid slot with last=1: set cfg_err, stay in IDLE.
    - Otherwise: latch the slot index, go to PAYLOAD_HI.
  - PAYLOAD_HI: latch the HI beat, go to PAYLOAD_LO. If last=1: cfg_err, return to IDLE, no write.
  - PAYLOAD_LO: write {hi,lo} to the latched shadow slot on acceptance. If last=1, go to IDLE. If last=0: the write still happens, cfg_err is set, go to DROP.
  - DROP: consume beats until a beat with last=1, then go to IDLE.
  - COMMIT_WAIT: cfg_ready_out=0.
    - In the first cycle with phv_in_valid==0 && pipe_busy==0, copy shadow to active on that clock edge.
    - In the same edge, commit_done<=1 for one cycle, action_out_valid<=1, and go to IDLE with cfg_ready_out<=1.
- cfg_ready_out is 1 in every state except COMMIT_WAIT.
- Shadow writes never alter action_out before a commit.
- Back-to-back commits are allowed; each waits for quiescence independently.
- cfg_err clears only on reset.

Optional Feature:
- Macro ACT_CFG_CLEAR_ON_COMMIT_EN.
- Defined: the commit edge also zeroes the whole shadow bank, so each configuration epoch starts clean; the active bank gets the pre-clear contents.
- Undefined: the shadow bank retains its contents after commit, enabling incremental updates.

Decomposition:
- Package rmt_cfg_pkg holds:
  - header field offsets and widths (stage id, slot, commit bit)
  - beat-count constants
  - the state enum encoding
- One natural sub-module, act_slot_bank: holds the shadow and active register arrays. It has a slot write port (index, data, enable), a commit/clear strobe and a flat active output. action_cfg_ctrl keeps only the FSM and protocol checking.

Test Plan:
- Write slot 3 = 0xDEADBEEF_01234567, then commit with phv_in_valid=pipe_busy=0 -> commit_done pulses 1 cycle after the commit beat. The slot-3 field of action_out = 0xDEADBEEF01234567, all other slots 0, action_out_valid=1.
- Commit while pipe_busy=1 for 5 cycles -> cfg_ready_out=0 and action_out unchanged for 5 cycles; swap and commit_done on the first cycle pipe_busy=0.
- Header with stage id = STAGE_ID+1 followed by 2 payload beats (last on the 3rd), then a valid write/commit -> the foreign payload is ignored, only the valid write appears, cfg_err=0.
- Write header with slot 70 -> cfg_err=1, packet dropped to last, no slot changes after commit.
- Write header then HI beat with last=1 -> cfg_err=1, no shadow change, FSM back in IDLE for the next header.
- Assert rst_n=0 during PAYLOAD_LO, then release -> all outputs 0, cfg_ready_out=1, and a fresh 3-beat write plus commit works normally.

Source files
------------

// File: rtl/rmt_cfg_pkg.sv
// Shared constants for the stage action configuration path:
// header field layout, packet beat counts and the controller state encoding.
package rmt_cfg_pkg;

    localparam int HDR_STAGE_LSB  = 24;
    localparam int HDR_STAGE_W    = 8;
    localparam int HDR_SLOT_LSB   = 17;
    localparam int HDR_SLOT_W     = 7;
    localparam int HDR_COMMIT_BIT = 16;

    localparam int WRITE_BEATS  = 3;
    localparam int COMMIT_BEATS = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAYLOAD_HI,
        ST_PAYLOAD_LO,
        ST_DROP,
        ST_COMMIT_WAIT
    } cfg_state_e;

endpackage

// File: rtl/action_cfg_ctrl_if.sv
// Configuration beat stream: valid/ready handshake with a last-beat marker.
interface action_cfg_ctrl_if #(
    parameter int CFG_W = 32
);
    logic [CFG_W-1:0] cfg_in_data;
    logic             cfg_in_valid;
    logic             cfg_in_last;
    logic             cfg_ready_out;

    modport master (
        output cfg_in_data,
        output cfg_in_valid,
        output cfg_in_last,
        input  cfg_ready_out
    );

    modport slave (
        input  cfg_in_data,
        input  cfg_in_valid,
        input  cfg_in_last,
        output cfg_ready_out
    );
endinterface

// File: rtl/act_slot_bank.sv
// Shadow/active sub-action register banks with a single slot write port.
// Build option ACT_CFG_CLEAR_ON_COMMIT_EN zeroes the shadow bank on commit.
module act_slot_bank #(
    parameter  int ACT_LEN    = 64,
    parameter  int C_NUM_PHVS = 65,
    localparam int IDX_W      = $clog2(C_NUM_PHVS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en_i,
    input  logic [IDX_W-1:0]              wr_idx_i,
    input  logic [ACT_LEN-1:0]            wr_data_i,
    input  logic                          commit_i,
    output logic [ACT_LEN*C_NUM_PHVS-1:0] act_o
);

    logic [ACT_LEN-1:0] shadow_q [C_NUM_PHVS];
    logic [ACT_LEN-1:0] active_q [C_NUM_PHVS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < C_NUM_PHVS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            if (commit_i) begin
                active_q <= shadow_q;
`ifdef ACT_CFG_CLEAR_ON_COMMIT_EN
                for (int k = 0; k < C_NUM_PHVS; k++) begin
                    shadow_q[k] <= '0;
                end
`endif
            end
            if (wr_en_i) begin
                shadow_q[wr_idx_i] <= wr_data_i;
            end
        end
    end

    // Slot 0 occupies the most significant ACT_LEN bits.
    always_comb begin
        act_o = '0;
        for (int k = 0; k < C_NUM_PHVS; k++) begin
            act_o[ACT_LEN*C_NUM_PHVS-1-k*ACT_LEN -: ACT_LEN] = active_q[k];
        end
    end

endmodule

// File: rtl/action_cfg_ctrl.sv
// Per-stage action configuration controller: parses config packets into the
// shadow bank and swaps it into the active bank once the stage is quiescent.
module action_cfg_ctrl
    import rmt_cfg_pkg::*;
#(
    parameter int STAGE_ID   = 0,
    parameter int ACT_LEN    = 64,
    parameter int C_NUM_PHVS = 65,
    parameter int CFG_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    action_cfg_ctrl_if.slave              cfg,
    input  logic                          phv_in_valid,
    input  logic                          pipe_busy,
    output logic [ACT_LEN*C_NUM_PHVS-1:0] action_out,
    output logic                          action_out_valid,
    output logic                          commit_done,
    output logic                          cfg_err
);

    cfg_state_e              state_q, state_d;
    logic [HDR_SLOT_W-1:0]   slot_q, slot_d;
    logic [CFG_W-1:0]        hi_q, hi_d;
    logic                    err_q, err_d;
    logic                    done_q;
    logic                    aval_q;

    logic                    accept;
    logic                    last;
    logic                    wr_en;
    logic                    commit;
    logic [HDR_STAGE_W-1:0]  hdr_stage;
    logic [HDR_SLOT_W-1:0]   hdr_slot;
    logic                    hdr_commit;
    logic                    stage_hit;
    logic                    slot_bad;

    assign cfg.cfg_ready_out = (state_q != ST_COMMIT_WAIT);
    assign accept     = cfg.cfg_in_valid && cfg.cfg_ready_out;
    assign last       = cfg.cfg_in_last;
    assign hdr_stage  = cfg.cfg_in_data[HDR_STAGE_LSB +: HDR_STAGE_W];
    assign hdr_slot   = cfg.cfg_in_data[HDR_SLOT_LSB +: HDR_SLOT_W];
    assign hdr_commit = cfg.cfg_in_data[HDR_COMMIT_BIT];
    assign stage_hit  = (hdr_stage == HDR_STAGE_W'(STAGE_ID));
    assign slot_bad   = (int'(hdr_slot) >= C_NUM_PHVS);

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        hi_d    = hi_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!stage_hit) begin
                        state_d = last ? ST_IDLE : ST_DROP;
                    end else if (hdr_commit) begin
                        if (last) begin
                            state_d = ST_COMMIT_WAIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_DROP;
                        end
                    end else if (slot_bad) begin
                        err_d   = 1'b1;
                        state_d = last ? ST_IDLE : ST_DROP;
                    end else if (last) begin
                        err_d   = 1'b1;
                    end else begin
                        slot_d  = hdr_slot;
                        state_d = ST_PAYLOAD_HI;
                    end
                end
            end
            ST_PAYLOAD_HI: begin
                if (accept) begin
                    if (last) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        hi_d    = cfg.cfg_in_data;
                        state_d = ST_PAYLOAD_LO;
                    end
                end
            end
            ST_PAYLOAD_LO: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (last) begin
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (accept && last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT_WAIT: begin
                if (!phv_in_valid && !pipe_busy) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            aval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            done_q  <= commit;
            aval_q  <= aval_q | commit;
        end
    end

    assign action_out_valid = aval_q;
    assign commit_done      = done_q;
    assign cfg_err          = err_q;

    act_slot_bank #(
        .ACT_LEN    (ACT_LEN),
        .C_NUM_PHVS (C_NUM_PHVS)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_idx_i   (slot_q),
        .wr_data_i  ({hi_q, cfg.cfg_in_data}),
        .commit_i   (commit),
        .act_o      (action_out)
    );

endmodule

// File: tb/tb_action_cfg_ctrl.sv
// Self-checking bench for action_cfg_ctrl: table of write/commit vectors
// plus hand sequences for foreign stage, bad slot, short packet and reset.
module tb_action_cfg_ctrl;
    import rmt_cfg_pkg::*;

    localparam int NS    = 65;
    localparam int W     = 64 * NS;
    localparam int STAGE = 0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         phv_in_valid = 1'b0;
    logic         pipe_busy = 1'b0;
    logic [W-1:0] action_out;
    logic         action_out_valid;
    logic         commit_done;
    logic         cfg_err;

    action_cfg_ctrl_if #(.CFG_W(32)) cfg_if ();

    action_cfg_ctrl #(
        .STAGE_ID   (STAGE),
        .ACT_LEN    (64),
        .C_NUM_PHVS (NS),
        .CFG_W      (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg              (cfg_if),
        .phv_in_valid     (phv_in_valid),
        .pipe_busy        (pipe_busy),
        .action_out       (action_out),
        .action_out_valid (action_out_valid),
        .commit_done      (commit_done),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        logic [63:0] data;
        int          hold;
        bit          use_phv;
    } vec_t;

    vec_t         vecs [6];
    logic [63:0]  sh_m [NS];
    logic [63:0]  act_m [NS];
    logic [W-1:0] sb [$];
    int           n_pass = 0;
    int           n_total = 0;

    function automatic logic [W-1:0] flat(input logic [63:0] a [NS]);
        logic [W-1:0] f;
        f = '0;
        for (int k = 0; k < NS; k++) f[W-1-k*64 -: 64] = a[k];
        return f;
    endfunction

    function automatic logic [31:0] hdr(input int st, input int slot, input bit c);
        return {8'(st), 7'(slot), c, 16'h0000};
    endfunction

    task automatic chk1(input string name, input logic got, input logic exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b required=%b", name, got, exp);
    endtask

    task automatic chk_bank(input string name, input logic [W-1:0] exp);
        int bad;
        n_total++;
        if (action_out === exp) begin
            n_pass++;
        end else begin
            bad = 0;
            for (int k = NS - 1; k >= 0; k--)
                if (action_out[W-1-k*64 -: 64] !== exp[W-1-k*64 -: 64]) bad = k;
            $display("FAIL %s slot=%0d got=%h required=%h", name, bad,
                     action_out[W-1-bad*64 -: 64], exp[W-1-bad*64 -: 64]);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        cfg_if.cfg_in_data  = d;
        cfg_if.cfg_in_valid = 1'b1;
        cfg_if.cfg_in_last  = l;
        @(negedge clk);
        while (!cfg_if.cfg_ready_out && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL send_timeout ready=%b required=1", cfg_if.cfg_ready_out);
        end
        @(posedge clk);
        #1;
        cfg_if.cfg_in_valid = 1'b0;
        cfg_if.cfg_in_last  = 1'b0;
    endtask

    task automatic do_write(input int slot, input logic [63:0] d);
        logic [31:0] b [WRITE_BEATS];
        b[0] = hdr(STAGE, slot, 1'b0);
        b[1] = d[63:32];
        b[2] = d[31:0];
        for (int i = 0; i < WRITE_BEATS; i++) send(b[i], i == WRITE_BEATS - 1);
        sh_m[slot] = d;
    endtask

    task automatic do_commit(input int hold, input bit use_phv);
        logic [W-1:0] old_w;
        int n;
        old_w = flat(act_m);
        if (hold > 0) begin
            if (use_phv) phv_in_valid = 1'b1;
            else pipe_busy = 1'b1;
        end
        for (int i = 0; i < COMMIT_BEATS; i++)
            send(hdr(STAGE, 0, 1'b1), i == COMMIT_BEATS - 1);
        sb.push_back(flat(sh_m));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk1("cw_ready_low", cfg_if.cfg_ready_out, 1'b0);
            chk1("cw_no_done", commit_done, 1'b0);
            chk_bank("cw_bank_hold", old_w);
            @(posedge clk);
            #1;
        end
        phv_in_valid = 1'b0;
        pipe_busy    = 1'b0;
        n = 0;
        @(negedge clk);
        while (!commit_done && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk1("commit_done", commit_done, 1'b1);
        chk1("commit_latency", n == 1, 1'b1);
        chk_bank("commit_bank", sb.pop_front());
        chk1("act_valid", action_out_valid, 1'b1);
        for (int k = 0; k < NS; k++) act_m[k] = sh_m[k];
`ifdef ACT_CFG_CLEAR_ON_COMMIT_EN
        for (int k = 0; k < NS; k++) sh_m[k] = '0;
`endif
        @(negedge clk);
        chk1("done_pulse_end", commit_done, 1'b0);
        chk1("ready_back", cfg_if.cfg_ready_out, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{3,  64'hDEADBEEF_01234567, 0, 1'b0};
        vecs[1] = '{0,  64'h11112222_33334444, 0, 1'b0};
        vecs[2] = '{64, 64'hA5A5A5A5_5A5A5A5A, 2, 1'b0};
        vecs[3] = '{3,  64'h0F0F0F0F_F0F0F0F0, 5, 1'b0};
        vecs[4] = '{32, 64'h80000000_00000001, 3, 1'b1};
        vecs[5] = '{1,  64'hFFFFFFFF_FFFFFFFF, 1, 1'b0};
        for (int k = 0; k < NS; k++) begin
            sh_m[k]  = '0;
            act_m[k] = '0;
        end
        cfg_if.cfg_in_data  = '0;
        cfg_if.cfg_in_valid = 1'b0;
        cfg_if.cfg_in_last  = 1'b0;

        repeat (2) @(negedge clk);
        chk_bank("rst_action", '0);
        chk1("rst_act_valid", action_out_valid, 1'b0);
        chk1("rst_done", commit_done, 1'b0);
        chk1("rst_err", cfg_err, 1'b0);
        chk1("rst_ready", cfg_if.cfg_ready_out, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // write then commit, shadow writes must stay invisible until commit
        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].slot, vecs[i].data);
            @(negedge clk);
            chk_bank("pre_commit_bank", flat(act_m));
            @(posedge clk);
            #1;
            do_commit(vecs[i].hold, vecs[i].use_phv);
        end

        // foreign stage packet is swallowed without error
        send(hdr(STAGE + 1, 10, 1'b0), 1'b0);
        send(32'hBAD0BAD0, 1'b0);
        send(32'hBAD1BAD1, 1'b1);
        do_write(10, 64'h0000CAFE_0000F00D);
        do_commit(0, 1'b0);
        chk1("foreign_no_err", cfg_err, 1'b0);

        // out-of-range slot
        send(hdr(STAGE, 70, 1'b0), 1'b0);
        @(negedge clk);
        chk1("bad_slot_err", cfg_err, 1'b1);
        @(posedge clk);
        #1;
        send(32'hFFFFFFFF, 1'b0);
        send(32'hEEEEEEEE, 1'b1);
        do_commit(0, 1'b0);

        // reset in PAYLOAD_LO
        send(hdr(STAGE, 20, 1'b0), 1'b0);
        send(32'h12345678, 1'b0);
        cfg_if.cfg_in_data  = 32'h9ABCDEF0;
        cfg_if.cfg_in_valid = 1'b1;
        cfg_if.cfg_in_last  = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_bank("midrst_action", '0);
        chk1("midrst_act_valid", action_out_valid, 1'b0);
        chk1("midrst_done", commit_done, 1'b0);
        chk1("midrst_err", cfg_err, 1'b0);
        chk1("midrst_ready", cfg_if.cfg_ready_out, 1'b1);
        cfg_if.cfg_in_valid = 1'b0;
        cfg_if.cfg_in_last  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < NS; k++) begin
            sh_m[k]  = '0;
            act_m[k] = '0;
        end
        do_write(64, 64'h13579BDF_2468ACE0);
        do_commit(0, 1'b0);
        chk1("post_rst_err", cfg_err, 1'b0);

        // HI beat carrying last aborts the write
        send(hdr(STAGE, 5, 1'b0), 1'b0);
        send(32'hCAFEBABE, 1'b1);
        @(negedge clk);
        chk1("short_write_err", cfg_err, 1'b1);
        @(posedge clk);
        #1;
        do_write(6, 64'h00000006_60000000);
        do_commit(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
